axi_ram_responder: RTL and testbench
====================================

// Module: axi_ram_responder
// PURPOSE
//  Single-beat AXI responder (slave) backed by on-chip RAM of 64-bit words. It is the
//  memory-side counterpart of the ACP initiator. It serves one write (AW/W/B) or one read
//  (AR/R) transaction at a time. Used as an on-chip scratch memory and as the responder
//  in initiator benches.
// PARAMETERS
//  BASE_ADDR  32'h80000000  byte address of word 0
//  DEPTH      1024          number of 64-bit words (power of 2, >= 2)
// PORTS
//  ACLK     in   1   clock, all logic on rising edge
//  ARESETn  in   1   synchronous active-low reset
//  AWADDR   in   32  write byte address
//  AWPROT   in   3   ignored
//  AWCACHE  in   4   ignored
//  AWUSER   in   1   ignored
//  AWVALID  in   1   write address valid
//  AWREADY  out  1   write address ready
//  WDATA    in   64  write data
//  WSTRB    in   8   byte enables; bit i selects WDATA[8i+7:8i]
//  WLAST    in   1   must be 1 (single beat)
//  WVALID   in   1   write data valid
//  WREADY   out  1   write data ready
//  BRESP    out  2   write response
//  BVALID   out  1   write response valid
//  BREADY   in   1   write response ready
//  ARADDR   in   32  read byte address
//  ARPROT   in   3   ignored
//  ARCACHE  in   4   ignored
//  ARUSER   in   1   ignored
//  ARVALID  in   1   read address valid
//  ARREADY  out  1   read address ready
//  RDATA    out  64  read data
//  RRESP    out  2   read response
//  RLAST    out  1   last beat; equals RVALID
//  RVALID   out  1   read data valid
//  RREADY   in   1   read data ready
// BEHAVIOUR
//  - Reset (ARESETn=0 at edge): state=IDLE; BVALID=RVALID=RLAST=0; BRESP=RRESP=2'b00;
//    RDATA=0. RAM contents are not cleared. Reset mid-transaction abandons it with no
//    partial write.
//  - A handshake occurs when VALID and READY are both 1 at an edge.
//  - Decode: idx=(addr-BASE_ADDR)>>3; addr[2:0] ignored. The address is in range iff
//    BASE_ADDR <= addr < BASE_ADDR+8*DEPTH. Out of range gives DECERR (2'b11): the write
//    is dropped and RDATA=0.
//  - States: IDLE, WR_DATA, WR_RESP, RD_DATA. READY outputs are combinational from state:
//    AWREADY=(IDLE); ARREADY=(IDLE && !AWVALID); WREADY=(WR_DATA).
//  - IDLE: AW handshake latches the address and goes to WR_DATA. Otherwise an AR handshake
//    reads RAM[idx] and goes to RD_DATA. If both are valid, the write wins.
//  - WR_DATA: W handshake writes the enabled bytes, then BVALID=1 next cycle -> WR_RESP.
//    BRESP is OKAY, or DECERR, or SLVERR (2'b10, write dropped) when WLAST=0.
//    WSTRB=0 gives OKAY with no change.
//  - WR_RESP: hold BVALID/BRESP until BREADY, then clear BVALID -> IDLE.
//  - RD_DATA: RVALID=RLAST=1 the cycle after the AR handshake. RDATA/RRESP are held stable
//    while RVALID && !RREADY. On RREADY: clear RVALID/RLAST/RRESP/RDATA -> IDLE.
//  - W presented before AW is held off (WREADY=0) until WR_DATA.
//  - Minimum cycle time: write = 3 cycles plus B wait; read = 2 cycles plus R wait.
//  - A read issued after a write's B handshake returns the newly written data.
// TESTING
//  - Write 64'h1122334455667788, WSTRB=FF to BASE+8 -> BVALID one cycle after W, BRESP=00;
//    read BASE+8 -> RDATA=64'h1122334455667788, RRESP=00, RLAST=1.
//  - WSTRB=8'h0F, WDATA=all-FF over that word -> read returns 64'h11223344FFFFFFFF.
//  - AWVALID and ARVALID high in the same cycle -> AWREADY=1, ARREADY=0; the write
//    completes and the read is served afterwards.
//  - AWADDR=BASE+8*DEPTH -> BRESP=11, RAM unchanged; ARADDR=BASE-8 -> RRESP=11, RDATA=0.
//  - Hold RREADY=0 for 5 cycles -> RVALID and RDATA stay constant. Hold BREADY=0 ->
//    BVALID held and AWREADY=0.
//  - Drop ARESETn during WR_DATA -> next cycle all outputs are at reset values and RAM is
//    unchanged.

Source files
------------

// File: rtl/axi_ram_responder.sv
// Single-beat AXI responder backed by a RAM of 64-bit words.
// It serves one transaction at a time: either a write (AW -> W -> B) or a read (AR -> R).
// Out-of-range addresses return DECERR. A write with WLAST=0 returns SLVERR.
// In both error cases the write is dropped and the RAM is left untouched.
module axi_ram_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h80000000,
    parameter int          DEPTH     = 1024
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    // write address channel
    input  logic [31:0] AWADDR,
    input  logic [2:0]  AWPROT,
    input  logic [3:0]  AWCACHE,
    input  logic        AWUSER,
    input  logic        AWVALID,
    output logic        AWREADY,
    // write data channel
    input  logic [63:0] WDATA,
    input  logic [7:0]  WSTRB,
    input  logic        WLAST,
    input  logic        WVALID,
    output logic        WREADY,
    // write response channel
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    // read address channel
    input  logic [31:0] ARADDR,
    input  logic [2:0]  ARPROT,
    input  logic [3:0]  ARCACHE,
    input  logic        ARUSER,
    input  logic        ARVALID,
    output logic        ARREADY,
    // read data channel
    output logic [63:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RLAST,
    output logic        RVALID,
    input  logic        RREADY
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2,
        RD_DATA = 2'd3
    } state_e;

    state_e          state_q;
    logic            aw_ok_q;
    logic [AW-1:0]   aw_idx_q;
    logic            bvalid_q;
    logic [1:0]      bresp_q;
    logic            rvalid_q;
    logic [1:0]      rresp_q;
    logic [63:0]     rdata_q;

    logic [63:0]     mem [DEPTH];

    logic [31:0]     aw_off;
    logic [31:0]     ar_off;
    logic            aw_in_range;
    logic            ar_in_range;
    logic            wr_hs;
    logic            wr_en;

    // Offsets from the window base. If the address is below the base, the subtraction wraps to
    // a value at or above SPAN, provided the window does not cross 2^32. So one unsigned
    // compare covers both bounds.
    assign aw_off      = AWADDR - BASE_ADDR;
    assign ar_off      = ARADDR - BASE_ADDR;
    assign aw_in_range = ({1'b0, aw_off} < SPAN);
    assign ar_in_range = ({1'b0, ar_off} < SPAN);

    // The READY outputs are pure decodes of the state. The write wins a tie because ARREADY
    // is masked by AWVALID.
    assign AWREADY = (state_q == IDLE);
    assign ARREADY = (state_q == IDLE) && !AWVALID;
    assign WREADY  = (state_q == WR_DATA);

    assign BVALID = bvalid_q;
    assign BRESP  = bresp_q;
    assign RVALID = rvalid_q;
    assign RLAST  = rvalid_q;
    assign RRESP  = rresp_q;
    assign RDATA  = rdata_q;

    // A W beat landing in the same cycle as reset must not reach the RAM.
    assign wr_hs = (state_q == WR_DATA) && WVALID && ARESETn;
    assign wr_en = wr_hs && aw_ok_q && WLAST;

    // Sideband inputs and the byte-lane address bits carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{AWPROT, AWCACHE, AWUSER, ARPROT, ARCACHE, ARUSER,
                         aw_off[2:0], ar_off[2:0]};

    // RAM write port with byte enables. The RAM has no reset, so its contents survive ARESETn.
    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (WSTRB[b]) mem[aw_idx_q][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    // Transaction FSM. Each response register is loaded on the handshake that moves to the
    // response state, and is cleared or held as the channel requires.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q  <= IDLE;
            aw_ok_q  <= 1'b0;
            aw_idx_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (AWVALID) begin
                        // Capture the decode now, because AWADDR may change after the handshake.
                        aw_ok_q  <= aw_in_range;
                        aw_idx_q <= aw_off[AW+2:3];
                        state_q  <= WR_DATA;
                    end else if (ARVALID) begin
                        rvalid_q <= 1'b1;
                        if (ar_in_range) begin
                            rdata_q <= mem[ar_off[AW+2:3]];
                            rresp_q <= RESP_OKAY;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= RESP_DECERR;
                        end
                        state_q  <= RD_DATA;
                    end
                end
                WR_DATA: begin
                    if (WVALID) begin
                        bvalid_q <= 1'b1;
                        if (!aw_ok_q)    bresp_q <= RESP_DECERR;
                        else if (!WLAST) bresp_q <= RESP_SLVERR;
                        else             bresp_q <= RESP_OKAY;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RD_DATA: begin
                    if (RREADY) begin
                        rvalid_q <= 1'b0;
                        rresp_q  <= RESP_OKAY;
                        rdata_q  <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_responder.sv
// Randomized bench for axi_ram_responder. The reference model is a word array plus the
// address-window rules.
module tb_axi_ram_responder;

    localparam logic [31:0] BASE  = 32'h80000000;
    localparam int          DEPTH = 16;
    localparam int          TMO   = 20;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic [3:0]  AWCACHE;
    logic        AWUSER;
    logic        AWVALID;
    logic        AWREADY;
    logic [63:0] WDATA;
    logic [7:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic [3:0]  ARCACHE;
    logic        ARUSER;
    logic        ARVALID;
    logic        ARREADY;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    int checks = 0;
    int errors = 0;

    logic [63:0] model [DEPTH];

    always #5 ACLK = ~ACLK;

    axi_ram_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWCACHE(AWCACHE), .AWUSER(AWUSER),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARCACHE(ARCACHE), .ARUSER(ARUSER),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        longint unsigned la = a;
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 8 * DEPTH);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    // Full write transaction. The expected response and the model update follow the window rules.
    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            input logic l, input int bwait);
        logic [1:0] er;
        int n;
        if (!in_win(a))  er = 2'b11;
        else if (!l)     er = 2'b10;
        else begin
            er = 2'b00;
            for (int b = 0; b < 8; b++)
                if (s[b]) model[word_of(a)][8*b +: 8] = d[8*b +: 8];
        end
        AWADDR = a; WDATA = d; WSTRB = s; WLAST = l;
        AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < TMO) begin @(posedge ACLK); #1; n++; end
        if (n == TMO) chk("aw_timeout", 0, 1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        WVALID  = 1'b1;
        n = 0;
        while (!WREADY && n < TMO) begin @(posedge ACLK); #1; n++; end
        if (n == TMO) chk("w_timeout", 0, 1);
        @(posedge ACLK); #1;
        WVALID = 1'b0;
        chk("bvalid_lat", BVALID, 1);
        for (int i = 0; i < bwait; i++) begin
            chk("bvalid_hold", BVALID, 1);
            chk("awready_busy", AWREADY, 0);
            chk("bresp_hold", BRESP, er);
            @(posedge ACLK); #1;
        end
        chk("bresp", BRESP, er);
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        chk("bvalid_clr", BVALID, 0);
    endtask

    // Full read transaction. The data is checked against the model and also returned to the caller.
    task automatic do_read(input logic [31:0] a, input int rwait, output logic [63:0] rd);
        logic [63:0] ed;
        logic [1:0]  er;
        int n;
        ed = in_win(a) ? model[word_of(a)] : 64'd0;
        er = in_win(a) ? 2'b00 : 2'b11;
        ARADDR  = a;
        ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < TMO) begin @(posedge ACLK); #1; n++; end
        if (n == TMO) chk("ar_timeout", 0, 1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        chk("rvalid_lat", RVALID, 1);
        chk("rlast", RLAST, 1);
        for (int i = 0; i < rwait; i++) begin
            chk("rvalid_hold", RVALID, 1);
            chk("rdata_hold", RDATA, ed);
            @(posedge ACLK); #1;
        end
        chk("rdata", RDATA, ed);
        chk("rresp", RRESP, er);
        rd = RDATA;
        RREADY = 1'b1;
        @(posedge ACLK); #1;
        RREADY = 1'b0;
        chk("rvalid_clr", RVALID, 0);
        chk("rdata_clr", RDATA, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r < 8) return BASE + 32'(8 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 7));
        if (r == 8) return BASE + 32'(8 * DEPTH) + 32'(8 * $urandom_range(0, 3));
        return BASE - 32'(8 * $urandom_range(1, 3));
    endfunction

    initial begin
        logic [63:0] rd;
        logic [31:0] a;
        ARESETn = 1'b0;
        AWADDR = '0; AWPROT = '0; AWCACHE = '0; AWUSER = 1'b0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b1; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARPROT = '0; ARCACHE = '0; ARUSER = 1'b0; ARVALID = 1'b0; RREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rlast", RLAST, 0);
        chk("rst_bresp", BRESP, 0);
        chk("rst_rresp", RRESP, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_awready", AWREADY, 1);
        chk("rst_wready", WREADY, 0);
        ARESETn = 1'b1;

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++)
            do_write(BASE + 32'(8 * i), {$urandom, $urandom}, 8'hFF, 1'b1, 0);

        // Basic write, then read back.
        do_write(BASE + 32'd8, 64'h1122334455667788, 8'hFF, 1'b1, 0);
        do_read(BASE + 32'd8, 0, rd);
        chk("dir_full", rd, 64'h1122334455667788);

        // Partial strobe.
        do_write(BASE + 32'd8, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 1'b1, 0);
        do_read(BASE + 32'd8, 0, rd);
        chk("dir_strb", rd, 64'h11223344FFFFFFFF);

        // A zero strobe changes nothing.
        do_write(BASE + 32'd8, 64'h0, 8'h00, 1'b1, 0);
        do_read(BASE + 32'd8, 0, rd);
        chk("dir_strb0", rd, 64'h11223344FFFFFFFF);

        // W offered before AW is held off.
        WVALID = 1'b1;
        #1;
        chk("w_before_aw", WREADY, 0);
        do_write(BASE + 32'd16, 64'hA5A5A5A5_5A5A5A5A, 8'hFF, 1'b1, 0);

        // AW and AR offered together: the write goes first, then the read sees the new data.
        ARADDR  = BASE + 32'd24;
        ARVALID = 1'b1;
        AWADDR  = BASE + 32'd24;
        AWVALID = 1'b1;
        #1;
        chk("tie_awready", AWREADY, 1);
        chk("tie_arready", ARREADY, 0);
        do_write(BASE + 32'd24, 64'hDEADBEEF_CAFEF00D, 8'hFF, 1'b1, 2);
        do_read(BASE + 32'd24, 0, rd);
        chk("tie_rd", rd, 64'hDEADBEEF_CAFEF00D);

        // Out-of-range write just past the window: DECERR, and the RAM is unchanged.
        do_write(BASE + 32'(8 * DEPTH), 64'h0123456789ABCDEF, 8'hFF, 1'b1, 0);
        do_read(BASE + 32'(8 * (DEPTH - 1)), 0, rd);
        do_read(BASE - 32'd8, 0, rd);
        chk("dir_decerr_rd", rd, 0);

        // Write with WLAST=0: SLVERR, and the write is dropped.
        do_write(BASE + 32'd8, 64'h0, 8'hFF, 1'b0, 0);
        do_read(BASE + 32'd8, 0, rd);
        chk("dir_slverr", rd, 64'h11223344FFFFFFFF);

        // Long stalls on both response channels.
        do_write(BASE + 32'd32, 64'h1357_9BDF_2468_ACE0, 8'hFF, 1'b1, 5);
        do_read(BASE + 32'd32, 5, rd);

        // Reset asserted in WR_DATA, together with a W beat: no write lands.
        AWADDR  = BASE + 32'd40;
        AWVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        chk("rst_mid_wready", WREADY, 1);
        WDATA = 64'hFFFF_0000_FFFF_0000; WSTRB = 8'hFF; WLAST = 1'b1; WVALID = 1'b1;
        ARESETn = 1'b0;
        @(posedge ACLK); #1;
        chk("rst_mid_bvalid", BVALID, 0);
        chk("rst_mid_rvalid", RVALID, 0);
        chk("rst_mid_rlast", RLAST, 0);
        chk("rst_mid_bresp", BRESP, 0);
        chk("rst_mid_rresp", RRESP, 0);
        chk("rst_mid_rdata", RDATA, 0);
        chk("rst_mid_wready0", WREADY, 0);
        chk("rst_mid_awready", AWREADY, 1);
        WVALID  = 1'b0;
        ARESETn = 1'b1;
        do_read(BASE + 32'd40, 0, rd);

        // Random mix of traffic.
        for (int t = 0; t < 300; t++) begin
            a = rand_addr();
            if ($urandom_range(0, 1) == 0)
                do_write(a, {$urandom, $urandom}, 8'($urandom),
                         in_win(a) ? ($urandom_range(0, 7) != 0) : 1'b1,
                         $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3), rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
